// File: rtl/ps2_rx_if.sv
// PS/2 receiver bundle: the raw keyboard lines in, the decoded scan code and
// its status strobes out, plus the receiver state for observation.
//
// Handshake: valid is a one-cycle strobe with no ready. code is only meaningful
// in the cycle valid is high and then holds until the next good frame. err is
// a one-cycle strobe that is never high together with valid.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       valid;
  logic       err;
  logic       busy;
  logic [1:0] state;

  // Keyboard / stimulus side.
  modport master (
    output ps2_clk, ps2_data,
    input  code, valid, err, busy, state
  );

  // Receiver side.
  modport slave (
    input  ps2_clk, ps2_data,
    output code, valid, err, busy, state
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard frame receiver. Synchronises and deglitches the raw lines,
// shifts in start/8 data/odd parity/stop, and presents each good scan code.
// A stalled frame is abandoned after TIMEOUT_CYCLES without a clock edge.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic     clk,
  input logic     reset,
  ps2_rx_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1, clk_s2, data_s1, data_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_level;
  logic                  fall;
  logic                  timeout;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic [7:0]    code, code_n;
  logic          valid, valid_n;
  logic          err, err_n;

  // Two-flop synchronisers; idle-high lines so they reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Clock deglitch: the level flips only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_sr    <= '1;
      filt_level <= 1'b1;
    end else begin
      filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      if (filt_sr == '1)
        filt_level <= 1'b1;
      else if (filt_sr == '0)
        filt_level <= 1'b0;
    end
  end

  // Strobe in the cycle the filtered level is about to drop from 1 to 0.
  assign fall = filt_level && (filt_sr == '0);

  // A clock edge arriving in the same cycle as expiry takes priority.
  assign timeout = (state != IDLE) && !fall && (idle_cnt == CW'(TIMEOUT_CYCLES));

  // Frame sequencing, stall counter and result strobes.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    idle_cnt_n = '0;
    code_n     = code;
    valid_n    = 1'b0;
    err_n      = 1'b0;

    if (state != IDLE)
      idle_cnt_n = fall ? '0 : idle_cnt + CW'(1);

    case (state)
      IDLE: begin
        // A high "start" bit is line noise: ignore it silently.
        if (fall && !data_s2) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {data_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = data_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (data_s2 && (^{shift, par})) begin
            code_n  = shift;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n    = IDLE;
      err_n      = 1'b1;
      idle_cnt_n = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      par      <= 1'b0;
      idle_cnt <= '0;
      code     <= 8'h00;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par      <= par_n;
      idle_cnt <= idle_cnt_n;
      code     <= code_n;
      valid    <= valid_n;
      err      <= err_n;
    end
  end

  assign bus.code  = code;
  assign bus.valid = valid;
  assign bus.err   = err;
  assign bus.busy  = (state != IDLE);
  assign bus.state = state;

endmodule
